ws2812_encoder: RTL
===================

// Module: ws2812_encoder
// PURPOSE
// - Transmit-side WS2812 serialiser. It is the counterpart of the capture/decode path.
// - Accepts packed GRB pixel words over a valid/ready handshake.
// - Emits the one-wire NRZ waveform: per-bit high/low pulse widths, then a low reset (latch) gap on request.
// - Sits between the pixel frame source and the LED data pin.
// PARAMETERS
// - T0H_CYCLES    20    high time of a '0' bit, in clk cycles (0.4us at 50MHz)
// - T1H_CYCLES    40    high time of a '1' bit, in clk cycles (0.8us at 50MHz)
// - BIT_CYCLES    63    total bit period, in clk cycles (1.26us at 50MHz)
// - RESET_CYCLES  2600  latch low period, in clk cycles (52us at 50MHz)
// - Elaboration check: 1 <= T0H_CYCLES < T1H_CYCLES < BIT_CYCLES. RESET_CYCLES >= 2.
// PORTS
// - i_clk           in   1   system clock
// - i_reset         in   1   asynchronous, active-high reset
// - i_pixel_data    in   PW  pixel word, MSB sent first (PW=24, or 32 with WS2812_RGBW_EN)
// - i_pixel_valid   in   1   i_pixel_data is valid
// - o_pixel_ready   out  1   encoder accepts a pixel this cycle
// - i_latch         in   1   request latch gap after the current pixel
// - o_dout          out  1   serial data to the LED chain (registered)
// - o_busy          out  1   high while a bit or a latch gap is in progress
// BEHAVIOUR
// - Reset values: o_dout=0, o_busy=0, state=IDLE, counters=0, shift reg=0.
//   o_pixel_ready is 1 while held in reset.
// - Reset is async. Asserting it mid-operation forces o_dout low immediately.
//   The in-flight pixel is discarded. No further pulses occur until a new accept.
// - FSM states:
//   - IDLE: o_dout=0.
//   - HIGH: o_dout=1 for THx cycles, where THx = T1H_CYCLES if the current bit is 1, else T0H_CYCLES.
//   - LOW: o_dout=0 for BIT_CYCLES-THx cycles.
//   - LATCH: o_dout=0 for RESET_CYCLES cycles.
// - Accept = i_pixel_valid && o_pixel_ready.
// - Latch accept = i_latch && ready condition.
// - Ready condition: state==IDLE, OR (state==LOW && last bit && final LOW cycle).
//   - o_pixel_ready = ready condition && !i_latch. Latch wins when both arrive together.
//   - The pixel is not taken and stays pending until after LATCH.
// - Accept on cycle N:
//   - Shift register loads on N.
//   - o_dout rises on N+1 (1-cycle latency). Same-edge accept gives back-to-back pixels with zero gap.
// - Bit period is exactly BIT_CYCLES cycles. A pixel lasts PW*BIT_CYCLES cycles.
// - Bits are sent MSB first. The caller packs G[23:16], R[15:8], B[7:0].
// - End of last bit with no accept and no latch: go to IDLE, o_dout stays 0.
//   Note: an idle gap >= RESET_CYCLES latches the LEDs anyway. Starving the input mid-frame is the caller's responsibility.
// - Latch accept enters LATCH on the next cycle:
//   - o_dout=0, o_busy=1, o_pixel_ready=0 for RESET_CYCLES cycles.
//   - Then IDLE, with ready high on the following cycle.
// - i_latch is ignored outside the ready condition (level, sampled only there).
// - o_busy=1 in HIGH, LOW and LATCH. o_busy=0 in IDLE.
// - Counters:
//   - Bit-phase counter width $clog2(BIT_CYCLES). Latch counter width $clog2(RESET_CYCLES+1).
//   - Both count up from 0 and clear on every phase change. They never wrap.
//   - Bit index counter counts PW-1 down to 0.
// CONFIGURATION
// - WS2812_RGBW_EN undefined: PW=24 (GRB). A pixel lasts 24*BIT_CYCLES cycles.
// - WS2812_RGBW_EN defined: PW=32 (GRBW, W in [7:0], sent last) for SK6812-RGBW chains.
//   A pixel lasts 32*BIT_CYCLES cycles. All other behaviour is unchanged.
// TESTING (defaults, 50MHz)
// - Reset: i_reset=1 for 5 cycles, then 0
//   -> o_dout=0, o_busy=0, o_pixel_ready=1.
// - Single pixel 0xA500FF accepted at N
//   -> o_dout high N+1..N+40, low 23 (bit23=1).
//   -> Next bit is high 20, low 43.
//   -> o_busy falls at N+1513 (24*63 cycles).
// - Two pixels, valid held high
//   -> o_pixel_ready pulses 1 cycle at final LOW cycle of bit 0.
//   -> Second pixel's first rise exactly 63 cycles after first pixel's last bit start (no gap).
// - i_latch=1 at final cycle of last bit
//   -> o_dout=0 and o_busy=1 for 2600 cycles, ready=0.
//   -> Back to IDLE, ready=1 next cycle.
// - i_latch and i_pixel_valid together in IDLE
//   -> Latch taken, ready=0 during it.
//   -> Pixel accepted after LATCH, with o_dout rising 1 cycle later.
// - i_reset pulse at 10th cycle of a HIGH phase
//   -> o_dout=0 same cycle, no pulses after release until a new accept.
//   -> With WS2812_RGBW_EN, one pixel occupies 2016 cycles and W[0] is the last bit.

Source files
------------

// File: rtl/ws2812_encoder_if.sv
// Pixel handshake bundle between the frame source (master) and the WS2812 encoder (slave).
// Pixel width follows WS2812_RGBW_EN: 24-bit GRB by default, 32-bit GRBW when defined.
interface ws2812_encoder_if;
`ifdef WS2812_RGBW_EN
    localparam int PW = 32;
`else
    localparam int PW = 24;
`endif

    logic [PW-1:0] pixel_data;
    logic          pixel_valid;
    logic          pixel_ready;
    logic          latch;

    modport master (output pixel_data, output pixel_valid, output latch, input pixel_ready);
    modport slave  (input pixel_data, input pixel_valid, input latch, output pixel_ready);
endinterface

// File: rtl/ws2812_encoder.sv
// WS2812 transmit serialiser: pixel words in over valid/ready, NRZ pulse train plus latch gap out.
// WS2812_RGBW_EN selects 32-bit GRBW pixels (SK6812-RGBW); otherwise 24-bit GRB.
//
// state | meaning
// IDLE  | no activity, o_dout low, ready for a pixel or latch request
// HIGH  | high part of the current bit (T1H or T0H cycles)
// LOW   | low remainder of the current bit period
// LATCH | low latch gap of RESET_CYCLES cycles
module ws2812_encoder #(
    parameter int T0H_CYCLES   = 20,
    parameter int T1H_CYCLES   = 40,
    parameter int BIT_CYCLES   = 63,
    parameter int RESET_CYCLES = 2600
) (
    input  logic               i_clk,
    input  logic               i_reset,
    ws2812_encoder_if.slave    pix,
    output logic               o_dout,
    output logic               o_busy
);

`ifdef WS2812_RGBW_EN
    localparam int PW = 32;
`else
    localparam int PW = 24;
`endif

    localparam int PHASE_W = $clog2(BIT_CYCLES);
    localparam int LATCH_W = $clog2(RESET_CYCLES + 1);
    localparam int IDX_W   = $clog2(PW);

    localparam logic [PHASE_W-1:0] T0H_LAST   = PHASE_W'(T0H_CYCLES - 1);
    localparam logic [PHASE_W-1:0] T1H_LAST   = PHASE_W'(T1H_CYCLES - 1);
    localparam logic [PHASE_W-1:0] T0L_LAST   = PHASE_W'(BIT_CYCLES - T0H_CYCLES - 1);
    localparam logic [PHASE_W-1:0] T1L_LAST   = PHASE_W'(BIT_CYCLES - T1H_CYCLES - 1);
    localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(RESET_CYCLES - 1);
    localparam logic [IDX_W-1:0]   IDX_MSB    = IDX_W'(PW - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HIGH  = 2'd1;
    localparam logic [1:0] S_LOW   = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    if (!(T0H_CYCLES >= 1 && T0H_CYCLES < T1H_CYCLES &&
          T1H_CYCLES < BIT_CYCLES && RESET_CYCLES >= 2)) begin : g_param_check
        $error("ws2812_encoder: invalid timing parameters");
    end

    logic [1:0]         state;
    logic [PHASE_W-1:0] phase_cnt;
    logic [LATCH_W-1:0] latch_cnt;
    logic [IDX_W-1:0]   bit_idx;
    logic [PW-1:0]      shreg;

    logic cur_bit;
    logic high_last;
    logic low_last;
    logic last_bit;
    logic rdy_cond;
    logic accept;
    logic latch_acc;

    assign cur_bit   = shreg[PW-1];
    assign high_last = (phase_cnt == (cur_bit ? T1H_LAST : T0H_LAST));
    assign low_last  = (phase_cnt == (cur_bit ? T1L_LAST : T0L_LAST));
    assign last_bit  = (bit_idx == '0);

    // Ready on the final LOW cycle of the last bit lets the next pixel follow with no gap.
    assign rdy_cond  = (state == S_IDLE) || (state == S_LOW && last_bit && low_last);
    assign latch_acc = pix.latch && rdy_cond;
    assign pix.pixel_ready = i_reset || (rdy_cond && !pix.latch);
    assign accept    = pix.pixel_valid && pix.pixel_ready;

    assign o_busy = (state != S_IDLE);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            latch_cnt <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            o_dout    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (latch_acc) begin
                        state     <= S_LATCH;
                        latch_cnt <= '0;
                    end else if (accept) begin
                        shreg     <= pix.pixel_data;
                        bit_idx   <= IDX_MSB;
                        phase_cnt <= '0;
                        state     <= S_HIGH;
                        o_dout    <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (high_last) begin
                        state     <= S_LOW;
                        phase_cnt <= '0;
                        o_dout    <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                S_LOW: begin
                    if (!low_last) begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end else if (!last_bit) begin
                        shreg     <= {shreg[PW-2:0], 1'b0};
                        bit_idx   <= bit_idx - 1'b1;
                        phase_cnt <= '0;
                        state     <= S_HIGH;
                        o_dout    <= 1'b1;
                    end else if (latch_acc) begin
                        state     <= S_LATCH;
                        phase_cnt <= '0;
                        latch_cnt <= '0;
                    end else if (accept) begin
                        shreg     <= pix.pixel_data;
                        bit_idx   <= IDX_MSB;
                        phase_cnt <= '0;
                        state     <= S_HIGH;
                        o_dout    <= 1'b1;
                    end else begin
                        phase_cnt <= '0;
                        state     <= S_IDLE;
                    end
                end
                S_LATCH: begin
                    if (latch_cnt == LATCH_LAST) begin
                        latch_cnt <= '0;
                        state     <= S_IDLE;
                    end else begin
                        latch_cnt <= latch_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
